// File: rtl/conv_tile_seq.sv
// conv_tile_seq: multi-channel tile convolution with channel accumulation,
// ReLU, signed output saturation and a valid/ready result handshake.
module conv_tile_seq #(
  parameter int K      = 3,
  parameter int TILE   = 4,
  parameter int STRIDE = 1,
  parameter int CH     = 3,
  parameter int DW     = 8,
  parameter int KW     = 8,
  parameter int OUTW   = 16,
  localparam int OUT   = (TILE - K) / STRIDE + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TILE*TILE*DW-1:0]    in_data,
  input  logic [K*K*KW-1:0]          in_kernel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT*OUT*OUTW-1:0]    out_data,
  output logic                       sat_flag
);

  localparam int AW = DW + KW + $clog2(K * K * CH) + 1;
  localparam int EW = (AW > OUTW) ? AW : OUTW + 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int NO = OUT * OUT;

  localparam logic signed [EW-1:0] MAXV = EW'((64'sd1 <<< (OUTW - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   relu_q;
  logic signed [AW-1:0]   acc       [NO];
  logic signed [AW-1:0]   beat_sum  [NO];
  logic signed [AW-1:0]   acc_next  [NO];
  logic [NO*OUTW-1:0]     res_data;
  logic                   res_sat;
  logic                   relu_eff;
  logic                   accept;
  logic                   last;

  logic signed [DW-1:0]   a_el;
  logic signed [KW-1:0]   w_el;
  logic signed [AW-1:0]   s_el;
  logic signed [EW-1:0]   v_el;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(CH - 1));

  // Dot product of the current beat's tile windows with its kernel channel
  always_comb begin
    a_el = '0;
    w_el = '0;
    s_el = '0;
    for (int unsigned o = 0; o < NO; o++) beat_sum[o] = '0;
    for (int unsigned i = 0; i < OUT; i++) begin
      for (int unsigned j = 0; j < OUT; j++) begin
        s_el = '0;
        for (int unsigned m = 0; m < K; m++) begin
          for (int unsigned n = 0; n < K; n++) begin
            a_el = in_data[((i * STRIDE + m) * TILE + j * STRIDE + n) * DW +: DW];
            w_el = in_kernel[(m * K + n) * KW +: KW];
            s_el = s_el + AW'(a_el) * AW'(w_el);
          end
        end
        beat_sum[i * OUT + j] = s_el;
      end
    end
  end

  // Channel-0 overwrites, later channels add; then ReLU and saturation of the sum
  // so the final beat's result can be registered on the same edge it is accepted.
  always_comb begin
    relu_eff = (cnt == '0) ? relu_en : relu_q;
    res_data = '0;
    res_sat  = 1'b0;
    v_el     = '0;
    for (int unsigned o = 0; o < NO; o++) begin
      if (cnt == '0) acc_next[o] = beat_sum[o];
      else           acc_next[o] = acc[o] + beat_sum[o];
      v_el = EW'(acc_next[o]);
      if (relu_eff && v_el < 0) v_el = '0;
      if (v_el > MAXV) begin
        v_el    = MAXV;
        res_sat = 1'b1;
      end else if (v_el < MINV) begin
        v_el    = MINV;
        res_sat = 1'b1;
      end
      res_data[o * OUTW +: OUTW] = v_el[OUTW-1:0];
    end
  end

  // ACC/OUT control, accumulators, channel counter and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      relu_q    <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int unsigned o = 0; o < NO; o++) acc[o] <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (clear) begin
            cnt <= '0;
          end else if (accept) begin
            for (int unsigned o = 0; o < NO; o++) acc[o] <= acc_next[o];
            if (cnt == '0) relu_q <= relu_en;
            if (last) begin
              cnt       <= '0;
              out_data  <= res_data;
              sat_flag  <= res_sat;
              state     <= ST_OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state     <= ST_ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_seq.sv
// Scoreboard bench for conv_tile_seq: default instance plus a TILE=5/STRIDE=2/CH=1 instance.
module tb_conv_tile_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default instance
  logic         reset;
  logic         d_clear, d_relu, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_sat;
  logic [127:0] d_in_data;
  logic [71:0]  d_in_kernel;
  logic [63:0]  d_out_data;

  // TILE=5, STRIDE=2, CH=1 instance
  logic         s_clear, s_relu, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sat;
  logic [199:0] s_in_data;
  logic [71:0]  s_in_kernel;
  logic [63:0]  s_out_data;

  logic [64:0] q_d[$];
  logic [64:0] q_s[$];

  conv_tile_seq dut_d (
    .clk(clk), .reset(reset), .clear(d_clear), .relu_en(d_relu),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .in_kernel(d_in_kernel), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .sat_flag(d_sat)
  );

  conv_tile_seq #(.TILE(5), .STRIDE(2), .CH(1)) dut_s (
    .clk(clk), .reset(reset), .clear(s_clear), .relu_en(s_relu),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_kernel(s_in_kernel), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .sat_flag(s_sat)
  );

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] fill_in(input logic [7:0] v);
    for (int i = 0; i < 16; i++) fill_in[i*8 +: 8] = v;
  endfunction

  function automatic logic [71:0] fill_k(input logic [7:0] v);
    for (int i = 0; i < 9; i++) fill_k[i*8 +: 8] = v;
  endfunction

  function automatic logic [63:0] fill_o(input logic [15:0] v);
    for (int i = 0; i < 4; i++) fill_o[i*16 +: 16] = v;
  endfunction

  // monitors: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!reset && d_out_valid && d_out_ready) begin
      if (q_d.size() == 0) chk("d_unexpected_out", {d_sat, d_out_data}, 65'h0);
      else chk("d_result", {d_sat, d_out_data}, q_d.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) chk("s_unexpected_out", {s_sat, s_out_data}, 65'h0);
      else chk("s_result", {s_sat, s_out_data}, q_s.pop_front());
    end
  end

  task automatic d_beat(input logic [127:0] data, input logic [71:0] kern,
                        input logic relu, input logic clr);
    d_in_data   = data;
    d_in_kernel = kern;
    d_relu      = relu;
    d_clear     = clr;
    d_in_valid  = 1'b1;
    @(posedge clk); #1;
    d_in_valid  = 1'b0;
    d_clear     = 1'b0;
  endtask

  task automatic s_beat(input logic [199:0] data, input logic [71:0] kern, input logic relu);
    s_in_data   = data;
    s_in_kernel = kern;
    s_relu      = relu;
    s_in_valid  = 1'b1;
    @(posedge clk); #1;
    s_in_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!d_in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!d_in_ready) chk(name, 65'(d_in_ready), 65'h1);
  endtask

  task automatic d_tile3(input logic [7:0] dv, input logic [7:0] kv, input logic relu);
    d_beat(fill_in(dv), fill_k(kv), relu, 1'b0);
    d_beat(fill_in(dv), fill_k(kv), 1'b0, 1'b0);
    d_beat(fill_in(dv), fill_k(kv), 1'b0, 1'b0);
  endtask

  logic [199:0] ramp;
  int           n_wait;

  initial begin
    reset = 1'b1;
    d_clear = 0; d_relu = 0; d_in_valid = 0; d_out_ready = 1;
    d_in_data = '0; d_in_kernel = '0;
    s_clear = 0; s_relu = 0; s_in_valid = 0; s_out_ready = 1;
    s_in_data = '0; s_in_kernel = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) ramp[(i*5+j)*8 +: 8] = 8'(i*5 + j);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_in_ready", 65'(d_in_ready), 65'h1);
    chk("rst_out_valid", 65'(d_out_valid), 65'h0);
    chk("rst_out_data", 65'(d_out_data), 65'h0);
    chk("rst_sat", 65'(d_sat), 65'h0);

    // ones: 27, one-cycle latency
    q_d.push_back({1'b0, fill_o(16'd27)});
    d_beat(fill_in(8'd1), fill_k(8'd1), 1'b0, 1'b0);
    d_beat(fill_in(8'd1), fill_k(8'd1), 1'b0, 1'b0);
    chk("pre_last_valid", 65'(d_out_valid), 65'h0);
    d_beat(fill_in(8'd1), fill_k(8'd1), 1'b0, 1'b0);
    chk("latency_valid", 65'(d_out_valid), 65'h1);
    chk("out_in_ready", 65'(d_in_ready), 65'h0);
    wait_idle("timeout_ones");

    // positive saturation
    q_d.push_back({1'b1, fill_o(16'h7fff)});
    d_tile3(8'd127, 8'd127, 1'b0);
    wait_idle("timeout_satp");

    // negative saturation
    q_d.push_back({1'b1, fill_o(16'h8000)});
    d_tile3(8'h80, 8'd127, 1'b0);
    wait_idle("timeout_satn");

    // negative result without and with ReLU (relu only on channel-0 beat)
    q_d.push_back({1'b0, fill_o(16'hffe5)});
    d_tile3(8'd1, 8'hff, 1'b0);
    wait_idle("timeout_neg");
    q_d.push_back({1'b0, fill_o(16'h0000)});
    d_tile3(8'd1, 8'hff, 1'b1);
    wait_idle("timeout_relu");

    // back-pressure: stable output, no acceptance, clear ignored in OUT
    d_out_ready = 1'b0;
    q_d.push_back({1'b0, fill_o(16'd27)});
    d_tile3(8'd1, 8'd1, 1'b0);
    d_in_data = fill_in(8'd5); d_in_kernel = fill_k(8'd1); d_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      d_clear = (c == 2);
      @(posedge clk); #1;
      chk("hold_data", 65'(d_out_data), 65'(fill_o(16'd27)));
      chk("hold_in_ready", 65'(d_in_ready), 65'h0);
      chk("hold_valid", 65'(d_out_valid), 65'h1);
    end
    d_in_valid = 1'b0; d_clear = 1'b0;
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 65'(d_in_ready), 65'h1);
    chk("release_valid", 65'(d_out_valid), 65'h0);

    // clear mid-tile, with a simultaneous beat that must be dropped
    d_beat(fill_in(8'd100), fill_k(8'd100), 1'b0, 1'b0);
    d_beat(fill_in(8'd100), fill_k(8'd100), 1'b0, 1'b0);
    d_beat(fill_in(8'd100), fill_k(8'd100), 1'b0, 1'b1);
    chk("clear_no_out", 65'(d_out_valid), 65'h0);
    q_d.push_back({1'b0, fill_o(16'd27)});
    d_tile3(8'd1, 8'd1, 1'b0);
    wait_idle("timeout_clear");

    // reset mid-tile
    d_beat(fill_in(8'd100), fill_k(8'd100), 1'b0, 1'b0);
    d_beat(fill_in(8'd100), fill_k(8'd100), 1'b0, 1'b0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    q_d.push_back({1'b0, fill_o(16'd27)});
    d_tile3(8'd1, 8'd1, 1'b0);
    wait_idle("timeout_rst_mid");

    // reset while a result is pending
    d_out_ready = 1'b0;
    d_tile3(8'd127, 8'd127, 1'b0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    chk("rst_out_valid2", 65'(d_out_valid), 65'h0);
    chk("rst_out_data2", 65'(d_out_data), 65'h0);
    chk("rst_sat2", 65'(d_sat), 65'h0);
    chk("rst_in_ready2", 65'(d_in_ready), 65'h1);
    d_out_ready = 1'b1;
    q_d.push_back({1'b0, fill_o(16'd27)});
    d_tile3(8'd1, 8'd1, 1'b0);
    wait_idle("timeout_rst_out");

    // TILE=5 STRIDE=2 CH=1: result after every beat
    q_s.push_back({1'b0, 16'd162, 16'd144, 16'd72, 16'd54});
    s_beat(ramp, fill_k(8'd1), 1'b0);
    chk("s_latency_valid", 65'(s_out_valid), 65'h1);
    @(posedge clk); #1;
    q_s.push_back({1'b0, 16'(-162), 16'(-144), 16'(-72), 16'(-54)});
    s_beat(ramp, fill_k(8'hff), 1'b0);
    @(posedge clk); #1;
    q_s.push_back({1'b0, 64'h0});
    s_beat(ramp, fill_k(8'hff), 1'b1);
    @(posedge clk); #1;

    n_wait = 0;
    while ((q_d.size() != 0 || q_s.size() != 0) && n_wait < 50) begin
      @(posedge clk); #1;
      n_wait++;
    end
    chk("q_d_drained", 65'(q_d.size()), 65'h0);
    chk("q_s_drained", 65'(q_s.size()), 65'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
